// File: rtl/txn_addr_mapper_pkg.sv
// txn_addr_mapper_pkg
//   Shared types for the TXN controller front end. Holds the address-field
//   widths, the read/write request enum, the captured host request record
//   and the mapped request record issued by txn_addr_mapper.
//   No ports; imported by the interface, the decoder and the mapper top.
package txn_addr_mapper_pkg;

    localparam int unsigned ROW_W   = 16;
    localparam int unsigned BANK_W  = 2;
    localparam int unsigned BG_W    = 2;
    localparam int unsigned COL_W   = 10;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned INDEX_W = 7;
    localparam int unsigned ADDR_W  = ROW_W + BANK_W + BG_W + COL_W;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

    // Raw host request as held in capture slot A.
    typedef struct packed {
        req_type_e            req_type;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
        logic [INDEX_W-1:0]   index;
    } host_req_t;

    // Decoded request as held in output slot B.
    typedef struct packed {
        req_type_e            req_type;
        logic [ROW_W-1:0]     row;
        logic [BANK_W-1:0]    bank;
        logic [BG_W-1:0]      bg;
        logic [COL_W-1:0]     col;
        logic [DATA_W-1:0]    data;
        logic [INDEX_W-1:0]   index;
    } mapped_req_t;

endpackage

// File: rtl/txn_addr_mapper_if.sv
// txn_addr_mapper_if
//   Host request channel (valid/ready) plus the mapped-request strobe bus.
//   master modport: host / consumer side (drives in_*, observes outputs).
//   slave  modport: txn_addr_mapper side.
//   Signals: in_valid, in_ready, in_type, in_addr, in_data, in_index,
//            mapper_valid, the_req_type, out_row, out_bank, out_bg,
//            out_col, out_data, out_index.
interface txn_addr_mapper_if
    import txn_addr_mapper_pkg::*;
();

    logic                 in_valid;
    logic                 in_ready;
    req_type_e            in_type;
    logic [ADDR_W-1:0]    in_addr;
    logic [DATA_W-1:0]    in_data;
    logic [INDEX_W-1:0]   in_index;

    logic                 mapper_valid;
    req_type_e            the_req_type;
    logic [ROW_W-1:0]     out_row;
    logic [BANK_W-1:0]    out_bank;
    logic [BG_W-1:0]      out_bg;
    logic [COL_W-1:0]     out_col;
    logic [DATA_W-1:0]    out_data;
    logic [INDEX_W-1:0]   out_index;

    modport master (
        output in_valid, in_type, in_addr, in_data, in_index,
        input  in_ready,
        input  mapper_valid, the_req_type, out_row, out_bank, out_bg,
               out_col, out_data, out_index
    );

    modport slave (
        input  in_valid, in_type, in_addr, in_data, in_index,
        output in_ready,
        output mapper_valid, the_req_type, out_row, out_bank, out_bg,
               out_col, out_data, out_index
    );

endinterface

// File: rtl/txn_addr_decode.sv
// txn_addr_decode
//   Purely combinational flat address -> {row, bank, bg, col} split.
//   Layout from LSB: col (COL_W), bg (BG_W), bank (BANK_W), row (ROW_W).
//   Optional macro TXN_BANK_XOR_EN: bank and bg are XORed with the low
//   row bits to spread row-strided traffic across banks.
//   Ports: addr in; row, bank, bg, col out.
module txn_addr_decode
    import txn_addr_mapper_pkg::*;
(
    input  logic [ADDR_W-1:0]  addr,
    output logic [ROW_W-1:0]   row,
    output logic [BANK_W-1:0]  bank,
    output logic [BG_W-1:0]    bg,
    output logic [COL_W-1:0]   col
);

    logic [ROW_W-1:0]  row_raw;
    logic [BANK_W-1:0] bank_raw;
    logic [BG_W-1:0]   bg_raw;

    always_comb begin
        col      = addr[COL_W-1:0];
        bg_raw   = addr[COL_W +: BG_W];
        bank_raw = addr[COL_W + BG_W +: BANK_W];
        row_raw  = addr[COL_W + BG_W + BANK_W +: ROW_W];
        row      = row_raw;
`ifdef TXN_BANK_XOR_EN
        bank     = bank_raw ^ row_raw[BANK_W-1:0];
        bg       = bg_raw ^ row_raw[BANK_W +: BG_W];
`else
        bank     = bank_raw;
        bg       = bg_raw;
`endif
    end

endmodule

// File: rtl/txn_addr_mapper.sv
// txn_addr_mapper
//   Front end of the TXN controller. Accepts host requests over a
//   valid/ready channel, decodes the flat address and issues at most one
//   mapped request per cycle as a one-cycle mapper_valid strobe. Two
//   register slots: A captures the host request, B holds the decoded
//   request being offered downstream. A request in B is held while the
//   over-flow stopper blocks its type; issue is strictly in order.
//   Optional macro TXN_BANK_XOR_EN (inside txn_addr_decode) changes the
//   bank/bg mapping only; timing is unchanged.
//   Ports: clk, rst (sync, active high), bus (slave modport of
//          txn_addr_mapper_if), stop_reading, stop_writing.
module txn_addr_mapper
    import txn_addr_mapper_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    txn_addr_mapper_if.slave   bus,
    input  logic               stop_reading,
    input  logic               stop_writing
);

    host_req_t   a_q, a_d;
    logic        a_full_q, a_full_d;
    mapped_req_t b_q, b_d;
    logic        b_full_q, b_full_d;

    logic              stop_sel;
    logic              fire_b;
    logic              move_a;
    logic              ready;
    logic              accept;
    logic [ROW_W-1:0]  dec_row;
    logic [BANK_W-1:0] dec_bank;
    logic [BG_W-1:0]   dec_bg;
    logic [COL_W-1:0]  dec_col;

    txn_addr_decode u_decode (
        .addr (a_q.addr),
        .row  (dec_row),
        .bank (dec_bank),
        .bg   (dec_bg),
        .col  (dec_col)
    );

    always_comb begin
        stop_sel = (b_q.req_type == REQ_READ) ? stop_reading : stop_writing;
        // Gated by rst so requests being flushed never strobe.
        fire_b   = !rst && b_full_q && !stop_sel;
        move_a   = a_full_q && (!b_full_q || fire_b);
        ready    = !rst && (!a_full_q || move_a);
        accept   = bus.in_valid && ready;

        a_d      = a_q;
        a_full_d = a_full_q;
        if (move_a) a_full_d = 1'b0;
        if (accept) begin
            a_full_d       = 1'b1;
            a_d.req_type   = bus.in_type;
            a_d.addr       = bus.in_addr;
            a_d.data       = bus.in_data;
            a_d.index      = bus.in_index;
        end

        b_d      = b_q;
        b_full_d = b_full_q;
        if (fire_b) b_full_d = 1'b0;
        if (move_a) begin
            b_full_d     = 1'b1;
            b_d.req_type = a_q.req_type;
            b_d.row      = dec_row;
            b_d.bank     = dec_bank;
            b_d.bg       = dec_bg;
            b_d.col      = dec_col;
            b_d.data     = a_q.data;
            b_d.index    = a_q.index;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            a_full_q <= 1'b0;
            b_q      <= '0;
            b_full_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            a_full_q <= a_full_d;
            b_q      <= b_d;
            b_full_q <= b_full_d;
        end
    end

    // Outputs mirror slot B; they simply hold when B drains.
    always_comb begin
        bus.in_ready     = ready;
        bus.mapper_valid = fire_b;
        bus.the_req_type = b_q.req_type;
        bus.out_row      = b_q.row;
        bus.out_bank     = b_q.bank;
        bus.out_bg       = b_q.bg;
        bus.out_col      = b_q.col;
        bus.out_data     = b_q.data;
        bus.out_index    = b_q.index;
    end

endmodule

// File: tb/tb_txn_addr_mapper.sv
module tb_txn_addr_mapper;
    import txn_addr_mapper_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stop_reading = 1'b0;
    logic stop_writing = 1'b0;

    txn_addr_mapper_if bus ();

    txn_addr_mapper dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .stop_reading (stop_reading),
        .stop_writing (stop_writing)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic               vld;
        req_type_e          typ;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
        logic [INDEX_W-1:0] idx;
        logic               sr;
        logic               sw;
        logic               e_ready;
        logic               e_valid;
        req_type_e          e_typ;
        logic [ADDR_W-1:0]  e_addr;
        logic [DATA_W-1:0]  e_data;
        logic [INDEX_W-1:0] e_idx;
    } vec_t;

    vec_t tbl[$];
    req_type_e         rt[128];
    logic [ADDR_W-1:0] ra[128];
    logic [DATA_W-1:0] rd[128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference address map, written with shifts/masks on a 32-bit copy.
    function automatic logic [31:0] m_row(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a);
        return (t >> (COL_W + BG_W + BANK_W)) & ((32'd1 << ROW_W) - 1);
    endfunction

    function automatic logic [31:0] m_bank(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = (32'(a) >> (COL_W + BG_W)) & ((32'd1 << BANK_W) - 1);
`ifdef TXN_BANK_XOR_EN
        t = t ^ (m_row(a) & ((32'd1 << BANK_W) - 1));
`endif
        return t;
    endfunction

    function automatic logic [31:0] m_bg(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = (32'(a) >> COL_W) & ((32'd1 << BG_W) - 1);
`ifdef TXN_BANK_XOR_EN
        t = t ^ ((m_row(a) >> BANK_W) & ((32'd1 << BG_W) - 1));
`endif
        return t;
    endfunction

    function automatic logic [31:0] m_col(input logic [ADDR_W-1:0] a);
        return 32'(a) & ((32'd1 << COL_W) - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input int unsigned r, input int unsigned b,
                                                  input int unsigned g, input int unsigned c);
        logic [31:0] t;
        t = (r << (COL_W + BG_W + BANK_W)) | (b << (COL_W + BG_W)) | (g << COL_W) | c;
        return t[ADDR_W-1:0];
    endfunction

    // One table row = one clock cycle. e_idx < 0 means no strobe expected.
    task automatic push(input logic vld, input req_type_e typ, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input int idx, input logic sr,
                        input logic sw, input logic e_ready, input int e_idx);
        vec_t v;
        v.vld = vld; v.typ = typ; v.addr = addr; v.data = data; v.idx = INDEX_W'(idx);
        v.sr = sr; v.sw = sw; v.e_ready = e_ready;
        if (vld) begin
            rt[idx] = typ; ra[idx] = addr; rd[idx] = data;
        end
        v.e_valid = (e_idx >= 0);
        if (v.e_valid) begin
            v.e_typ = rt[e_idx]; v.e_addr = ra[e_idx]; v.e_data = rd[e_idx];
            v.e_idx = INDEX_W'(e_idx);
        end else begin
            v.e_typ = REQ_READ; v.e_addr = '0; v.e_data = '0; v.e_idx = '0;
        end
        tbl.push_back(v);
    endtask

    task automatic idle(input logic e_ready, input int e_idx);
        push(1'b0, REQ_READ, '0, '0, 0, 1'b0, 1'b0, e_ready, e_idx);
    endtask

    task automatic drive(input logic vld, input req_type_e typ, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [INDEX_W-1:0] idx);
        bus.in_valid = vld; bus.in_type = typ; bus.in_addr = addr;
        bus.in_data = data; bus.in_index = idx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        drive(1'b0, REQ_READ, '0, '0, '0);

        // ---- table construction ----
        // Single read: strobe two edges after acceptance, exactly once.
        push(1'b1, REQ_READ, 30'h2A5C3F7, 16'h0000, 5, 1'b0, 1'b0, 1'b1, -1);
        idle(1'b1, -1);
        idle(1'b1, 5);
        idle(1'b1, -1);
        // Eight back-to-back writes at full rate.
        for (int k = 0; k < 10; k++) begin
            if (k < 8)
                push(1'b1, REQ_WRITE, mk_addr(32'h100 + k, k % 4, (k + 1) % 4, 32'h3FF - k * 7),
                     16'hA000 + 16'(k), k, 1'b0, 1'b0, 1'b1, (k >= 2) ? k - 2 : -1);
            else
                idle(1'b1, k - 2);
        end
        idle(1'b1, -1);
        // Read stalled in B blocks a write in A; third request refused.
        push(1'b1, REQ_READ,  mk_addr(16'h1234, 2, 1, 10'h011), 16'h0, 10, 1'b1, 1'b0, 1'b1, -1);
        push(1'b1, REQ_WRITE, mk_addr(16'h4321, 3, 3, 10'h022), 16'hBEEF, 11, 1'b1, 1'b0, 1'b1, -1);
        push(1'b1, REQ_WRITE, mk_addr(16'hFFFF, 1, 0, 10'h3FF), 16'hCAFE, 12, 1'b1, 1'b0, 1'b0, -1);
        push(1'b1, REQ_WRITE, mk_addr(16'hFFFF, 1, 0, 10'h3FF), 16'hCAFE, 12, 1'b1, 1'b0, 1'b0, -1);
        push(1'b1, REQ_WRITE, mk_addr(16'hFFFF, 1, 0, 10'h3FF), 16'hCAFE, 12, 1'b0, 1'b0, 1'b1, 10);
        idle(1'b1, 11);
        idle(1'b1, 12);
        idle(1'b1, -1);
        // Write stalled in B blocks reads behind it.
        push(1'b1, REQ_WRITE, mk_addr(16'h0ABC, 0, 3, 10'h100), 16'h5555, 20, 1'b0, 1'b1, 1'b1, -1);
        push(1'b1, REQ_READ,  mk_addr(16'h0DEF, 1, 1, 10'h200), 16'h0, 21, 1'b0, 1'b1, 1'b1, -1);
        push(1'b1, REQ_READ,  mk_addr(16'h8000, 2, 2, 10'h001), 16'h0, 22, 1'b0, 1'b1, 1'b0, -1);
        push(1'b1, REQ_READ,  mk_addr(16'h8000, 2, 2, 10'h001), 16'h0, 22, 1'b0, 1'b0, 1'b1, 20);
        idle(1'b1, 21);
        idle(1'b1, 22);
        idle(1'b1, -1);
        // stop_writing has no effect on a pure read stream.
        for (int k = 0; k < 8; k++) begin
            if (k < 6)
                push(1'b1, REQ_READ, mk_addr(32'h7000 + k * 3, (k + 2) % 4, k % 4, 32'h40 * k),
                     16'h0, 30 + k, 1'b0, 1'b1, 1'b1, (k >= 2) ? 28 + k : -1);
            else
                push(1'b0, REQ_READ, '0, '0, 0, 1'b0, 1'b1, 1'b1, 28 + k);
        end
        idle(1'b1, -1);

        // ---- reset ----
        tick();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_mapper_valid", 32'(bus.mapper_valid), 32'd0);
        tick();
        rst = 1'b0;
        #4;
        chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_reset_mapper_valid", 32'(bus.mapper_valid), 32'd0);
        chk("post_reset_out_row", 32'(bus.out_row), 32'd0);
        chk("post_reset_out_col", 32'(bus.out_col), 32'd0);
        chk("post_reset_out_index", 32'(bus.out_index), 32'd0);
        tick();

        // ---- table application ----
        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].typ, tbl[i].addr, tbl[i].data, tbl[i].idx);
            stop_reading = tbl[i].sr;
            stop_writing = tbl[i].sw;
            #4;
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d_mapper_valid", i), 32'(bus.mapper_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_type", i),  32'(bus.the_req_type), 32'(tbl[i].e_typ));
                chk($sformatf("v%0d_row", i),   32'(bus.out_row),   m_row(tbl[i].e_addr));
                chk($sformatf("v%0d_bank", i),  32'(bus.out_bank),  m_bank(tbl[i].e_addr));
                chk($sformatf("v%0d_bg", i),    32'(bus.out_bg),    m_bg(tbl[i].e_addr));
                chk($sformatf("v%0d_col", i),   32'(bus.out_col),   m_col(tbl[i].e_addr));
                chk($sformatf("v%0d_data", i),  32'(bus.out_data),  32'(tbl[i].e_data));
                chk($sformatf("v%0d_index", i), 32'(bus.out_index), 32'(tbl[i].e_idx));
            end
            tick();
        end

        // ---- reset with both slots full flushes them ----
        stop_reading = 1'b1; stop_writing = 1'b0;
        drive(1'b1, REQ_READ, mk_addr(1, 1, 1, 1), 16'h0, 7'd40);
        tick();
        drive(1'b1, REQ_READ, mk_addr(2, 2, 2, 2), 16'h0, 7'd41);
        tick();
        drive(1'b1, REQ_READ, mk_addr(3, 3, 3, 3), 16'h0, 7'd42);
        #4;
        chk("flush_full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b1; stop_reading = 1'b0;
        #4;
        chk("flush_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("flush_rst_mapper_valid", 32'(bus.mapper_valid), 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, REQ_READ, '0, '0, '0);
        #4;
        chk("flush_after_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_after_mapper_valid", 32'(bus.mapper_valid), 32'd0);
        chk("flush_after_out_index", 32'(bus.out_index), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            #4;
            chk($sformatf("flush_quiet%0d", k), 32'(bus.mapper_valid), 32'd0);
            tick();
        end

        // ---- bank/bg mapping with row=3, bank=1, bg=2 ----
        a = mk_addr(3, 1, 2, 10'h055);
        drive(1'b1, REQ_READ, a, 16'h0, 7'd50);
        tick();
        drive(1'b0, REQ_READ, '0, '0, '0);
        tick();
        #4;
        chk("map_valid", 32'(bus.mapper_valid), 32'd1);
        chk("map_row", 32'(bus.out_row), 32'h0003);
        chk("map_col", 32'(bus.out_col), 32'h055);
`ifdef TXN_BANK_XOR_EN
        chk("map_bank", 32'(bus.out_bank), 32'd2);
        chk("map_bg", 32'(bus.out_bg), 32'd2);
`else
        chk("map_bank", 32'(bus.out_bank), 32'd1);
        chk("map_bg", 32'(bus.out_bg), 32'd2);
`endif
        tick();
        #4;
        chk("map_single_strobe", 32'(bus.mapper_valid), 32'd0);
        chk("map_hold_index", 32'(bus.out_index), 32'd50);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/txn_addr_mapper.md
Name: txn_addr_mapper

Overview:
- Front-end stage of the TXN controller, directly upstream of the over-flow stopper and the read/write request buffers.
- Accepts host requests on a valid/ready interface and splits the flat address into row, bank, bank group and column.
- Emits at most one mapped request per cycle as a one-cycle mapper_valid strobe.
- Holds requests in order whenever the stopper asserts stop_reading or stop_writing for the request's type.

Parameters:
- ROW_W, 16, row address bits
- BANK_W, 2, bank bits within a group
- BG_W, 2, bank-group bits
- COL_W, 10, column bits
- DATA_W, 16, write data width
- INDEX_W, 7, request tag width, returned to the host with the response

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  host request present
- in_ready  out  1  mapper accepts the request this cycle
- in_type  in  1  request type, read/write enum from types_def
- in_addr  in  ROW_W+BANK_W+BG_W+COL_W  flat address
- in_data  in  DATA_W  write data, don't-care for reads
- in_index  in  INDEX_W  request tag
- stop_reading  in  1  from the over-flow stopper
- stop_writing  in  1  from the over-flow stopper
- mapper_valid  out  1  one-cycle strobe: mapped request issued
- the_req_type  out  1  type of the issued request
- out_row  out  ROW_W  mapped row
- out_bank  out  BANK_W  mapped bank
- out_bg  out  BG_W  mapped bank group
- out_col  out  COL_W  mapped column
- out_data  out  DATA_W  write data
- out_index  out  INDEX_W  request tag

Behaviour:
- Address map: col = addr[COL_W-1:0]; bg = next BG_W bits; bank = next BANK_W bits; row = top ROW_W bits.
- Pipeline has two register slots, A (capture) and B (output), each with a full flag. No other buffering.
- Reset (rst=1 at a clock edge): A and B full flags clear, mapper_valid=0, all out_* fields=0. in_ready is 0 during the reset cycle. Requests in flight are dropped; no strobe is issued for them.
- stop_sel = stop_reading when B type is read, else stop_writing.
- fire_B = B_full && !stop_sel.
- mapper_valid = fire_B (combinational on the stop inputs). out_* reflect slot B whenever B_full; they hold their last value when B is empty.
- move_A = A_full && (!B_full || fire_B). B loads the decoded A contents on move_A.
- in_ready = !A_full || move_A. A captures the host fields on in_valid && in_ready.
- Strict in-order issue: a stalled read in B also blocks a following write in A, and vice versa.
- Latency: a request accepted at edge N can strobe mapper_valid in cycle N+1 at the earliest (B loads at edge N+1).
- Throughput: 1 request/cycle when unstalled. Fire, move and accept may all happen in the same cycle.
- Under a stall, slots fill in order B then A; in_ready then drops to 0. Host fields are ignored while in_ready=0.
- A stop asserted with B empty has no effect until a request of that type reaches B.
- Stop inputs are used as given. The stopper's +1 margin covers its one-cycle registered latency; the mapper adds no extra guard.

Optional Feature:
- Macro: TXN_BANK_XOR_EN.
- Defined: out_bank = addr bank bits XOR row[BANK_W-1:0], and out_bg = addr bg bits XOR row[BANK_W+BG_W-1:BANK_W]. This spreads row-strided traffic across banks.
- Undefined: plain bit-slice map as above.
- Latency and handshake are identical in both builds.

Decomposition:
- types_def gains: ROW_W, BANK_W, BG_W, COL_W, DATA_W, INDEX_W localparams, and a packed struct mapped_req_t {type, row, bank, bg, col, data, index}.
- The existing read/write enum is reused from types_def.
- One natural sub-module: txn_addr_decode, purely combinational flat address -> {row, bank, bg, col}. It contains the TXN_BANK_XOR_EN logic and is instantiated between slot A and slot B.

Test Plan:
- Reset, then a single read with addr=0x2A5_C3F7, index=5 -> mapper_valid high exactly once, 2 edges after acceptance; row=0x0A97, bank=0, bg=0, col=0x3F7 (TXN_BANK_XOR_EN undefined).
- 8 back-to-back writes, stops low -> in_ready stays 1; 8 consecutive mapper_valid strobes with indexes 0..7 in order.
- Read parked in B with stop_reading=1, write arrives behind it -> write not issued and in_ready=0 after the third request; drop stop_reading -> read strobe, then write strobe next cycle.
- stop_writing=1 while only reads flow -> no stall; every read strobes at full rate.
- rst=1 for one cycle with both slots full -> next cycle mapper_valid=0, in_ready=1, no strobe for the flushed requests.
- TXN_BANK_XOR_EN defined, addr row=0x0003, bank=1, bg=2 -> out_bank=2, out_bg=2.
